// File: rtl/fifo_bypass_flex_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_pkg : shared constants, width typedefs and pointer wrap helper for  |
// |            fifo_bypass_flex.                                             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package fifo_pkg;

   localparam int FIFO_MIN_DEPTH         = 2;
   localparam int FIFO_DEFAULT_DEPTH     = 4;
   localparam int FIFO_DEFAULT_CNT_WIDTH = $clog2(FIFO_DEFAULT_DEPTH + 1);
   localparam int FIFO_DEFAULT_PTR_WIDTH = $clog2(FIFO_DEFAULT_DEPTH);

   typedef logic [FIFO_DEFAULT_CNT_WIDTH-1:0] fifo_cnt_t;
   typedef logic [FIFO_DEFAULT_PTR_WIDTH-1:0] fifo_ptr_t;

   // Explicit wrap so non-power-of-2 depths work.
   function automatic int unsigned f__ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_bypass_flex_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_bypass_flex_if : producer/consumer/control bundle of the FIFO.      |
// | Error flags exist only when FIFO_BYPASS_FLEX_ASSERT_EN is defined.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface fifo_bypass_flex_if #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 4
);
   localparam int CNT_WIDTH = $clog2(DEPTH + 1);

   logic                  i__data_in_valid;
   logic [DATA_WIDTH-1:0] i__data_in;
   logic                  o__data_in_ready;
   logic                  o__data_in_ready__next;
   logic                  o__data_out_valid;
   logic [DATA_WIDTH-1:0] o__data_out;
   logic                  i__data_out_ready;
   logic                  i__clear_all;
   logic [CNT_WIDTH-1:0]  i__af_thresh;
   logic                  o__almost_full;
   logic [CNT_WIDTH-1:0]  o__count;
`ifdef FIFO_BYPASS_FLEX_ASSERT_EN
   logic                  o__err_overflow;
   logic                  o__err_underflow;
`endif

   modport slave (
      input  i__data_in_valid, i__data_in, i__data_out_ready, i__clear_all, i__af_thresh,
      output o__data_in_ready, o__data_in_ready__next, o__data_out_valid, o__data_out,
             o__almost_full, o__count
`ifdef FIFO_BYPASS_FLEX_ASSERT_EN
      , output o__err_overflow, o__err_underflow
`endif
   );

   modport master (
      output i__data_in_valid, i__data_in, i__data_out_ready, i__clear_all, i__af_thresh,
      input  o__data_in_ready, o__data_in_ready__next, o__data_out_valid, o__data_out,
             o__almost_full, o__count
`ifdef FIFO_BYPASS_FLEX_ASSERT_EN
      , input o__err_overflow, o__err_underflow
`endif
   );

endinterface
`default_nettype wire

// File: rtl/fifo_bypass_flex_storage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_flex_storage : DEPTH x DATA_WIDTH register file, one synchronous    |
// |                     write port, combinational read at rd_ptr.            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fifo_flex_storage #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 4,
   parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
   input  wire logic                  clk,
   input  wire logic                  wr_en,
   input  wire logic [PTR_WIDTH-1:0]  wr_ptr,
   input  wire logic [DATA_WIDTH-1:0] wr_data,
   input  wire logic [PTR_WIDTH-1:0]  rd_ptr,
   output logic      [DATA_WIDTH-1:0] rd_data
);

   // Payload flops carry no reset; validity is tracked by the count.
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_ptr] <= wr_data;
      end
   end

   assign rd_data = r_mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fifo_bypass_flex.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_bypass_flex : FWFT FIFO with optional 0-cycle bypass, occupancy and |
// |   almost-full. Macro FIFO_BYPASS_FLEX_ASSERT_EN adds error flags + SVA.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fifo_bypass_flex
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 4,
   parameter int BYPASS     = 1
) (
   input wire logic         clk,
   input wire logic         reset,
   fifo_bypass_flex_if.slave bus
);

   localparam int CNT_WIDTH = $clog2(DEPTH + 1);
   localparam int PTR_WIDTH = $clog2(DEPTH);
   localparam logic [CNT_WIDTH-1:0] C_DEPTH = CNT_WIDTH'(DEPTH);

   generate
      if (DEPTH < FIFO_MIN_DEPTH) begin : g_depth_check
         $error("fifo_bypass_flex: DEPTH below minimum");
      end
   endgenerate

   logic [PTR_WIDTH-1:0]  r_wr_ptr;
   logic [PTR_WIDTH-1:0]  r_rd_ptr;
   logic [CNT_WIDTH-1:0]  r_count;
   logic [CNT_WIDTH-1:0]  w_count_next;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic                  w_count_nz;
   logic                  w_in_ready;
   logic                  w_out_valid;
   logic                  w_bypass_valid;
   logic                  w_bypass_fire;
   logic                  w_push;
   logic                  w_pop;

   assign w_count_nz = (r_count != '0);

   generate
      if (BYPASS != 0) begin : g_bypass
         assign w_bypass_valid = ~w_count_nz & bus.i__data_in_valid & ~bus.i__clear_all & ~reset;
      end else begin : g_no_bypass
         assign w_bypass_valid = 1'b0;
      end
   endgenerate

   // Ready depends only on the registered count, never on the consumer.
   assign w_in_ready    = (r_count < C_DEPTH) & ~reset & ~bus.i__clear_all;
   assign w_out_valid   = ~reset & ~bus.i__clear_all & (w_count_nz | w_bypass_valid);
   assign w_bypass_fire = w_bypass_valid & bus.i__data_out_ready;
   assign w_push        = bus.i__data_in_valid & w_in_ready & ~w_bypass_fire;
   assign w_pop         = w_out_valid & bus.i__data_out_ready & w_count_nz;

   assign w_count_next = bus.i__clear_all ? '0
                       : r_count + CNT_WIDTH'(w_push) - CNT_WIDTH'(w_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (bus.i__clear_all) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= PTR_WIDTH'(f__ptr_inc(32'(r_wr_ptr), DEPTH));
         end
         if (w_pop) begin
            r_rd_ptr <= PTR_WIDTH'(f__ptr_inc(32'(r_rd_ptr), DEPTH));
         end
         r_count <= w_count_next;
      end
   end

   fifo_flex_storage #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .PTR_WIDTH  (PTR_WIDTH)
   ) u_storage (
      .clk     (clk),
      .wr_en   (w_push),
      .wr_ptr  (r_wr_ptr),
      .wr_data (bus.i__data_in),
      .rd_ptr  (r_rd_ptr),
      .rd_data (w_rd_data)
   );

   assign bus.o__data_in_ready       = w_in_ready;
   assign bus.o__data_in_ready__next = (w_count_next < C_DEPTH) & ~reset;
   assign bus.o__data_out_valid      = w_out_valid;
   assign bus.o__data_out            = ~w_out_valid ? '0
                                     : (w_count_nz ? w_rd_data : bus.i__data_in);
   assign bus.o__almost_full         = ~reset & (r_count >= bus.i__af_thresh);
   assign bus.o__count               = reset ? '0 : r_count;

`ifdef FIFO_BYPASS_FLEX_ASSERT_EN
   logic r_err_overflow;
   logic r_err_underflow;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err_overflow  <= 1'b0;
         r_err_underflow <= 1'b0;
      end else if (bus.i__clear_all) begin
         r_err_overflow  <= 1'b0;
         r_err_underflow <= 1'b0;
      end else begin
         if (bus.i__data_in_valid & ~w_in_ready) begin
            r_err_overflow <= 1'b1;
         end
         if (bus.i__data_out_ready & ~w_out_valid) begin
            r_err_underflow <= 1'b1;
         end
      end
   end

   assign bus.o__err_overflow  = r_err_overflow;
   assign bus.o__err_underflow = r_err_underflow;

   a_count_le_depth : assert property (@(posedge clk) disable iff (reset) r_count <= C_DEPTH);
   a_ptr_consistent : assert property (@(posedge clk) disable iff (reset)
      ((32'(r_wr_ptr) + 32'(DEPTH) - 32'(r_rd_ptr)) % 32'(DEPTH)) == (32'(r_count) % 32'(DEPTH)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_bypass_flex.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fifo_bypass_flex : directed self-checking bench, DEPTH=4/3 bypass and |
// |                       DEPTH=4 registered-only instances.                 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fifo_bypass_flex;

   logic clk;
   logic reset;
   int   tests;
   int   fails;

   fifo_bypass_flex_if #(.DATA_WIDTH(64), .DEPTH(4)) if4 ();
   fifo_bypass_flex_if #(.DATA_WIDTH(64), .DEPTH(3)) if3 ();
   fifo_bypass_flex_if #(.DATA_WIDTH(64), .DEPTH(4)) ifb ();

   fifo_bypass_flex #(.DATA_WIDTH(64), .DEPTH(4), .BYPASS(1)) u_d4 (.clk(clk), .reset(reset), .bus(if4.slave));
   fifo_bypass_flex #(.DATA_WIDTH(64), .DEPTH(3), .BYPASS(1)) u_d3 (.clk(clk), .reset(reset), .bus(if3.slave));
   fifo_bypass_flex #(.DATA_WIDTH(64), .DEPTH(4), .BYPASS(0)) u_b0 (.clk(clk), .reset(reset), .bus(ifb.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int src;
      int rcv;
      tests = 0;
      fails = 0;
      reset = 1'b1;
      if4.i__data_in_valid = 1'b0; if4.i__data_in = '0; if4.i__data_out_ready = 1'b0;
      if4.i__clear_all = 1'b0;     if4.i__af_thresh = 3'd3;
      if3.i__data_in_valid = 1'b0; if3.i__data_in = '0; if3.i__data_out_ready = 1'b0;
      if3.i__clear_all = 1'b0;     if3.i__af_thresh = 2'd3;
      ifb.i__data_in_valid = 1'b0; ifb.i__data_in = '0; ifb.i__data_out_ready = 1'b0;
      ifb.i__clear_all = 1'b0;     ifb.i__af_thresh = 3'd0;

      // Reset state
      tick(); tick();
      chk("rst_count",    64'(if4.o__count), 64'd0);
      chk("rst_in_ready", 64'(if4.o__data_in_ready), 64'd0);
      chk("rst_out_vld",  64'(if4.o__data_out_valid), 64'd0);
      chk("rst_af_thr0",  64'(ifb.o__almost_full), 64'd0);
      reset = 1'b0;
      tick();
      chk("rel_in_ready", 64'(if4.o__data_in_ready), 64'd1);
      chk("af_thr0",      64'(ifb.o__almost_full), 64'd1);
      ifb.i__af_thresh = 3'd5;

      // Bypass with consumer ready
      if4.i__data_in_valid = 1'b1; if4.i__data_in = 64'hA5; if4.i__data_out_ready = 1'b1;
      #1;
      chk("byp_valid", 64'(if4.o__data_out_valid), 64'd1);
      chk("byp_data",  if4.o__data_out, 64'hA5);
      tick();
      if4.i__data_in_valid = 1'b0;
      #1;
      chk("byp_count", 64'(if4.o__count), 64'd0);
      chk("idle_data", if4.o__data_out, 64'd0);

      // Stall then bypass
      tick();
      if4.i__data_in_valid = 1'b1; if4.i__data_in = 64'h11; if4.i__data_out_ready = 1'b0;
      #1;
      chk("stall_data0", if4.o__data_out, 64'h11);
      tick();
      if4.i__data_in_valid = 1'b0;
      #1;
      chk("stall_count", 64'(if4.o__count), 64'd1);
      chk("stall_data1", if4.o__data_out, 64'h11);
      if4.i__data_out_ready = 1'b1;
      tick();
      if4.i__data_out_ready = 1'b0;
      #1;
      chk("stall_drain", 64'(if4.o__count), 64'd0);

      // Fill to full with almost-full threshold 3
      for (int k = 1; k <= 4; k++) begin
         tick();
         if4.i__data_in_valid = 1'b1; if4.i__data_in = 64'(k);
         #1;
         chk("fill_ready", 64'(if4.o__data_in_ready), 64'd1);
         chk("fill_af",    64'(if4.o__almost_full), (k == 4) ? 64'd1 : 64'd0);
      end
      tick();
      if4.i__data_in = 64'd5; if4.i__data_out_ready = 1'b1;
      #1;
      chk("full_count",  64'(if4.o__count), 64'd4);
      chk("full_ready",  64'(if4.o__data_in_ready), 64'd0);
      chk("full_rnext",  64'(if4.o__data_in_ready__next), 64'd1);
      chk("full_head",   if4.o__data_out, 64'd1);
      tick();
      if4.i__data_in_valid = 1'b0; if4.i__data_out_ready = 1'b0;
      #1;
      chk("pop_count", 64'(if4.o__count), 64'd3);
      chk("pop_head2", if4.o__data_out, 64'd2);
      if4.i__data_out_ready = 1'b1;
      tick();
      chk("pop_head3", if4.o__data_out, 64'd3);
      tick();
      chk("pop_head4", if4.o__data_out, 64'd4);
      tick();
      if4.i__data_out_ready = 1'b0;
      #1;
      chk("drain_count", 64'(if4.o__count), 64'd0);
      chk("drain_valid", 64'(if4.o__data_out_valid), 64'd0);

      // Clear with two stored words and a word offered
      tick();
      if4.i__data_in_valid = 1'b1; if4.i__data_in = 64'h21;
      tick();
      if4.i__data_in = 64'h22;
      tick();
      if4.i__data_in = 64'h23; if4.i__clear_all = 1'b1;
      #1;
      chk("clr_count", 64'(if4.o__count), 64'd2);
      chk("clr_valid", 64'(if4.o__data_out_valid), 64'd0);
      chk("clr_ready", 64'(if4.o__data_in_ready), 64'd0);
      tick();
      if4.i__clear_all = 1'b0; if4.i__data_in_valid = 1'b0;
      #1;
      chk("clr_after", 64'(if4.o__count), 64'd0);
      chk("clr_nohead", 64'(if4.o__data_out_valid), 64'd0);

      // Registered-only variant: no same-cycle forwarding
      tick();
      ifb.i__data_in_valid = 1'b1; ifb.i__data_in = 64'h77; ifb.i__data_out_ready = 1'b1;
      #1;
      chk("nb_valid0", 64'(ifb.o__data_out_valid), 64'd0);
      tick();
      ifb.i__data_in_valid = 1'b0;
      #1;
      chk("nb_valid1", 64'(ifb.o__data_out_valid), 64'd1);
      chk("nb_data",   ifb.o__data_out, 64'h77);
      chk("nb_af_hi",  64'(ifb.o__almost_full), 64'd0);
      tick();
      ifb.i__data_out_ready = 1'b0;
      #1;
      chk("nb_count", 64'(ifb.o__count), 64'd0);

      // Wrap on DEPTH=3 with random consumer stalls
      src = 0;
      rcv = 0;
      for (int c = 0; c < 200 && rcv < 10; c++) begin
         tick();
         if3.i__data_in_valid  = (src < 10);
         if3.i__data_in        = 64'(src);
         if3.i__data_out_ready = 1'($urandom_range(0, 1));
         #1;
         if (if3.o__data_out_valid && if3.i__data_out_ready) begin
            chk("wrap_order", if3.o__data_out, 64'(rcv));
            rcv++;
         end
         if (if3.i__data_in_valid && if3.o__data_in_ready) src++;
      end
      tick();
      if3.i__data_in_valid = 1'b0; if3.i__data_out_ready = 1'b0;
      #1;
      chk("wrap_total", 64'(rcv), 64'd10);
      chk("wrap_empty", 64'(if3.o__count), 64'd0);

      // Asynchronous reset mid-stream with three stored words
      if4.i__af_thresh = 3'd1;
      for (int k = 0; k < 3; k++) begin
         tick();
         if4.i__data_in_valid = 1'b1; if4.i__data_in = 64'(8'h31 + k);
      end
      tick();
      if4.i__data_in_valid = 1'b0;
      #1;
      chk("pre_rst_count", 64'(if4.o__count), 64'd3);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_count", 64'(if4.o__count), 64'd0);
      chk("arst_ready", 64'(if4.o__data_in_ready), 64'd0);
      chk("arst_rnext", 64'(if4.o__data_in_ready__next), 64'd0);
      chk("arst_valid", 64'(if4.o__data_out_valid), 64'd0);
      chk("arst_data",  if4.o__data_out, 64'd0);
      chk("arst_af",    64'(if4.o__almost_full), 64'd0);
      tick();
      reset = 1'b0;
      #1;
      chk("post_rst_count", 64'(if4.o__count), 64'd0);
      chk("post_rst_ready", 64'(if4.o__data_in_ready), 64'd1);
      chk("post_rst_valid", 64'(if4.o__data_out_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
